// File: rtl/alu_issue_stage.sv
// Registered issue/writeback stage around the 64-bit combinational ALU.
// Holds the architectural {V,C,N,Z} status and feeds stored C back as ALU carry-in.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_fsec,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [4:0]       alu_fsec,
  output logic             alu_carry,
  input  logic [63:0]      alu_fout,
  input  logic [3:0]       alu_signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [3:0]       out_status,
  output logic [3:0]       status_q,
  input  logic             status_clr,
  output logic             illegal_op,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic        accept, consume;
  logic        illegal, cv_upd;
  logic [63:0] res;
  logic [3:0]  flags;

  // alu_signal[1:0] (ALU's own Z/N) are deliberately ignored
  logic unused_sig;
  assign unused_sig = ^alu_signal[1:0];

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign alu_carry = status_q[2];

  always_comb begin
    illegal = alu_fsec > 5'b10000;
    res     = illegal ? 64'd0 : alu_fout;
    cv_upd  = (alu_fsec == 5'b00010) || (alu_fsec == 5'b00011);
    flags   = {cv_upd ? alu_signal[3] : status_q[3],
               cv_upd ? alu_signal[2] : status_q[2],
               res[63],
               res == 64'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_status <= '0;
      illegal_op <= 1'b0;
      op_count   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fsec   <= '0;
    end else begin
      if (accept) begin
        alu_a    <= in_a;
        alu_b    <= in_b;
        alu_fsec <= in_fsec;
      end
      if (consume) op_count <= op_count + CNT_W'(1);
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          out_result <= res;
          out_status <= flags;
          illegal_op <= illegal;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: if (consume) begin
          out_valid <= 1'b0;
          state     <= in_valid ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear wins over a same-cycle capture; out_status still gets the computed flags
  always_ff @(posedge clk) begin
    if (rst)               status_q <= '0;
    else if (status_clr)   status_q <= '0;
    else if (state == EXEC) status_q <= flags;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, directed table, hand sequences, randomized ops vs model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_fsec = '0;
  logic [63:0] in_a = '0, in_b = '0;
  logic [63:0] alu_a, alu_b, alu_fout;
  logic [4:0]  alu_fsec;
  logic        alu_carry;
  logic [3:0]  alu_signal;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_result;
  logic [3:0]  out_status, status_q;
  logic        status_clr = 1'b0;
  logic        illegal_op;
  logic [15:0] op_count;

  int n_vec = 0, n_err = 0;
  int m_cnt = 0;
  logic [3:0] m_st = '0;

  alu_issue_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fsec(in_fsec),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_fsec(alu_fsec),
    .alu_carry(alu_carry), .alu_fout(alu_fout), .alu_signal(alu_signal),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_status(out_status), .status_q(status_q), .status_clr(status_clr),
    .illegal_op(illegal_op), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU stand-in: returns {signal, result}; signal bits for non-add ops and [1:0] are decoys
  function automatic logic [67:0] alu_fn(input logic [4:0] f, input logic [63:0] a, b, input logic cin);
    logic [64:0] s;
    logic [63:0] r;
    logic c, v;
    s = '0; c = a[0]; v = b[0];
    case (f)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00010: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64];
                      v = (a[63] == b[63]) && (r[63] != a[63]); end
      5'b00011: begin s = {1'b0, a} + {1'b0, b} + {64'd0, cin}; r = s[63:0]; c = s[64];
                      v = (a[63] == b[63]) && (r[63] != a[63]); end
      5'b00100: r = a ^ b;
      5'b00110: r = a - b;
      default:  r = (f > 5'b10000) ? 64'd0 : a;
    endcase
    return {v, c, ~r[63], r != 64'd0, r};
  endfunction

  always_comb {alu_signal, alu_fout} = alu_fn(alu_fsec, alu_a, alu_b, alu_carry);

  // stage-level reference: result and {V,C,N,Z} a completed op should present
  function automatic logic [67:0] model_cap(input logic [4:0] f, input logic [63:0] a, b, input logic [3:0] st);
    logic [67:0] o;
    logic [63:0] r;
    logic [1:0]  vc;
    o  = alu_fn(f, a, b, st[2]);
    r  = (f > 5'b10000) ? 64'd0 : o[63:0];
    vc = (f == 5'b00010 || f == 5'b00011) ? o[67:66] : st[3:2];
    return {vc, r[63], r == 64'd0, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] f, input logic [63:0] a, b, input logic clr, input int stall,
                        output logic [63:0] r, output logic [3:0] os, sq, output logic il,
                        output logic [63:0] mr, output logic [3:0] mos, msq);
    logic [67:0] m;
    m = model_cap(f, a, b, m_st);
    mr = m[63:0]; mos = m[67:64]; msq = clr ? 4'b0 : m[67:64];
    @(negedge clk);
    in_valid = 1'b1; in_fsec = f; in_a = a; in_b = b; out_ready = 1'b0;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_fsec = 5'($urandom); in_a = {$urandom, $urandom};
    chk("exec_out_valid", 64'(out_valid), 64'd0);
    chk("exec_in_ready", 64'(in_ready), 64'd0);
    status_clr = clr;
    @(posedge clk); #1;
    status_clr = 1'b0;
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    r = out_result; os = out_status; sq = status_q; il = illegal_op;
    m_st = msq;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_result", out_result, r);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_cnt++;
    chk("op_count", 64'(op_count), 64'(m_cnt[15:0]));
    chk("post_consume_valid", 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [4:0]  f;
    logic [63:0] a, b;
    logic        clr;
    logic [63:0] res;
    logic [3:0]  ost, sq;
    logic        ill;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r, mr, r0;
    logic [3:0]  os, sq, mos, msq;
    logic        il;
    logic [4:0]  f;
    logic [63:0] a, b;
    int          c0;

    tbl[0] = '{5'b00010, 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101, 4'b0101, 1'b0};
    tbl[2] = '{5'b00011, 64'd0, 64'd0, 1'b0, 64'd1, 4'b0000, 4'b0000, 1'b0};
    tbl[3] = '{5'b00110, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 4'b0010, 1'b0};
    tbl[4] = '{5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101, 4'b0101, 1'b0};
    tbl[5] = '{5'b00110, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110, 4'b0110, 1'b0};
    tbl[6] = '{5'b00010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, 4'b1010, 1'b0};
    tbl[7] = '{5'b00011, 64'd0, 64'd0, 1'b0, 64'd0, 4'b0001, 4'b0001, 1'b0};
    tbl[8] = '{5'b10101, 64'd7, 64'd9, 1'b1, 64'd0, 4'b0001, 4'b0000, 1'b1};
    tbl[9] = '{5'b10000, 64'h1234, 64'd9, 1'b0, 64'h1234, 4'b0000, 4'b0000, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_status", 64'(out_status), 64'd0);
    chk("rst_status_q", 64'(status_q), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_fsec", 64'(alu_fsec), 64'd0);
    chk("rst_alu_carry", 64'(alu_carry), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].clr, 0, r, os, sq, il, mr, mos, msq);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
      chk($sformatf("tbl%0d_out_status", i), 64'(os), 64'(tbl[i].ost));
      chk($sformatf("tbl%0d_status_q", i), 64'(sq), 64'(tbl[i].sq));
      chk($sformatf("tbl%0d_illegal", i), 64'(il), 64'(tbl[i].ill));
    end

    // backpressure: 5 stalled cycles with a waiting input, then release accepts same cycle
    @(negedge clk);
    in_valid = 1'b1; in_fsec = 5'b00010; in_a = 64'd10; in_b = 64'd20; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 64'd100; in_b = 64'd1;
    @(posedge clk); #1;
    chk("bp_result", out_result, 64'd30);
    c0 = m_cnt;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_stable", out_result, 64'd30);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_count", 64'(op_count), 64'(c0[15:0]));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    m_cnt++;
    chk("bp_release_count", 64'(op_count), 64'(m_cnt[15:0]));
    chk("bp_exec_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("bp_second_result", out_result, 64'd101);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_cnt++;
    m_st = 4'b0000;
    chk("bp_second_count", 64'(op_count), 64'(m_cnt[15:0]));

    // throughput: one op per two cycles with both sides always ready
    @(negedge clk);
    in_valid = 1'b1; in_fsec = 5'b00010; in_a = 64'd1; in_b = 64'd1; out_ready = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_cnt += 8;
    chk("tput_count", 64'(op_count), 64'(m_cnt[15:0]));
    chk("tput_valid", 64'(out_valid), 64'd0);
    chk("tput_status", 64'(status_q), 64'd0);

    // randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      f = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) f = 5'($urandom_range(2, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
      if ($urandom_range(0, 5) == 0) b = 64'($urandom_range(0, 1));
      run_op(f, a, b, $urandom_range(0, 7) == 0, $urandom_range(0, 3), r, os, sq, il, mr, mos, msq);
      chk("rnd_result", r, mr);
      chk("rnd_out_status", 64'(os), 64'(mos));
      chk("rnd_status_q", 64'(sq), 64'(msq));
      chk("rnd_illegal", 64'(il), 64'(f > 5'b10000));
    end

    // reset during EXEC discards the op
    @(negedge clk);
    in_valid = 1'b1; in_fsec = 5'b00010; in_a = 64'd5; in_b = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0; m_st = '0;
    chk("rstx_out_valid", 64'(out_valid), 64'd0);
    chk("rstx_op_count", 64'(op_count), 64'd0);
    chk("rstx_status_q", 64'(status_q), 64'd0);
    chk("rstx_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("rstx_no_late_valid", 64'(out_valid), 64'd0);
    r0 = 64'd0;
    run_op(5'b00010, 64'd5, 64'd3, 1'b0, 1, r, os, sq, il, mr, mos, msq);
    chk("rstx_after_result", r, 64'd8 + r0);
    chk("rstx_after_count", 64'(op_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
